// File: rtl/rw_solve_pkg.sv
// Shared defaults and helpers for the multi-key conflict table.
// Provides key-field bit-offset helper and slot-index width derivation.
// Pure package: no logic, no latency, no backpressure.
package rw_solve_pkg;

  localparam int KEY_W_DEF    = 12;
  localparam int NUM_KEYS_DEF = 2;

  // LSB position of key field idx inside a packed tuple of key_w-bit fields.
  function automatic int key_lsb(input int idx, input int key_w);
    return idx * key_w;
  endfunction

  // Slot index width; never below one bit so a 2-entry table still works.
  function automatic int loc_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rw_solve_mk_lowest_free_enc.sv
// First-zero priority encoder over the slot valid vector.
// Combinational, zero latency.
// No flow control; any_free qualifies idx.
//
// Ports: used  - occupied/blocked slot bits
//        idx   - lowest index with used==0 (0 when none)
//        any_free - at least one zero bit present
module lowest_free_enc #(
  parameter int N = 64,
  parameter int W = 6
) (
  input  logic [N-1:0] used,
  output logic [W-1:0] idx,
  output logic         any_free
);

  // Scan downward so the last assignment wins with the lowest free index.
  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!used[i]) begin
        idx      = W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rw_solve_mk.sv
// Multi-key conflict table: admits a key tuple only if no field collides with the same field of a resident entry.
// Insert result 1 cycle after the request edge; delete applies at the edge, del_error 1 cycle later.
// No backpressure: a request is always answered; a full table or conflict yields insert_success=0.
//
// Ports: clk, rst_n (async active-low); valid_insert/keys_in request an insert;
//        valid_delete/del_loc_in release a slot; valid_out, keys_out, insert_success,
//        insert_loc, conflict_mask report the insert; full/occupancy are registered
//        table status; del_error flags a delete of an empty or out-of-range slot.
// Build option: RW_SOLVE_SAME_CYCLE_FREE_EN lets a slot deleted this cycle be reallocated.
module rw_solve_mk
  import rw_solve_pkg::*;
#(
  parameter int KEY_W     = KEY_W_DEF,
  parameter int NUM_KEYS  = NUM_KEYS_DEF,
  parameter int QUEUE_LEN = 64,
  parameter int LOC_WIDTH = loc_width(QUEUE_LEN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_insert,
  input  logic [NUM_KEYS*KEY_W-1:0] keys_in,
  input  logic                      valid_delete,
  input  logic [LOC_WIDTH-1:0]      del_loc_in,
  output logic                      valid_out,
  output logic [NUM_KEYS*KEY_W-1:0] keys_out,
  output logic                      insert_success,
  output logic [LOC_WIDTH-1:0]      insert_loc,
  output logic [NUM_KEYS-1:0]       conflict_mask,
  output logic                      full,
  output logic [LOC_WIDTH:0]        occupancy,
  output logic                      del_error
);

  logic [QUEUE_LEN-1:0]      valid_q;
  logic [QUEUE_LEN-1:0]      valid_d;
  logic [QUEUE_LEN-1:0]      del_hit;
  logic [QUEUE_LEN-1:0]      cmp_vld;
  logic [QUEUE_LEN-1:0]      busy;
  logic [QUEUE_LEN-1:0]      alloc_hit;
  logic [NUM_KEYS*KEY_W-1:0] keys_q [QUEUE_LEN];
  logic [NUM_KEYS-1:0]       mask_c;
  logic [LOC_WIDTH-1:0]      free_idx;
  logic                      any_free;
  logic                      ins_ok;
  logic                      del_ok;
  logic [LOC_WIDTH:0]        occ_d;

  // One-hot of the slot being validly released; out-of-range or empty targets match nothing.
  always_comb begin
    del_hit = '0;
    for (int s = 0; s < QUEUE_LEN; s++) begin
      del_hit[s] = valid_delete && valid_q[s] && (del_loc_in == LOC_WIDTH'(s));
    end
  end

  assign del_ok  = |del_hit;
  // A slot leaving this cycle no longer blocks the incoming tuple.
  assign cmp_vld = valid_q & ~del_hit;

  always_comb begin
    mask_c = '0;
    for (int s = 0; s < QUEUE_LEN; s++) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (cmp_vld[s] &&
            (keys_q[s][key_lsb(k, KEY_W) +: KEY_W] == keys_in[key_lsb(k, KEY_W) +: KEY_W])) begin
          mask_c[k] = 1'b1;
        end
      end
    end
  end

`ifdef RW_SOLVE_SAME_CYCLE_FREE_EN
  // The released slot is immediately reusable.
  assign busy = valid_q & ~del_hit;
`else
  // The released slot stays blocked for allocation until the next cycle.
  assign busy = valid_q;
`endif

  lowest_free_enc #(
    .N (QUEUE_LEN),
    .W (LOC_WIDTH)
  ) u_free_enc (
    .used     (busy),
    .idx      (free_idx),
    .any_free (any_free)
  );

  assign ins_ok = valid_insert && (mask_c == '0) && any_free;

  always_comb begin
    alloc_hit = '0;
    for (int s = 0; s < QUEUE_LEN; s++) begin
      alloc_hit[s] = ins_ok && (free_idx == LOC_WIDTH'(s));
    end
  end

  // Allocation is ORed after the clear so a reused slot keeps its valid bit.
  assign valid_d = (valid_q & ~del_hit) | alloc_hit;
  assign occ_d   = occupancy + (LOC_WIDTH + 1)'(ins_ok) - (LOC_WIDTH + 1)'(del_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q        <= '0;
      valid_out      <= 1'b0;
      keys_out       <= '0;
      insert_success <= 1'b0;
      insert_loc     <= '0;
      conflict_mask  <= '0;
      full           <= 1'b0;
      occupancy      <= '0;
      del_error      <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      valid_out      <= valid_insert;
      keys_out       <= valid_insert ? keys_in : '0;
      insert_success <= ins_ok;
      insert_loc     <= ins_ok ? free_idx : '0;
      conflict_mask  <= valid_insert ? mask_c : '0;
      occupancy      <= occ_d;
      full           <= (occ_d == (LOC_WIDTH + 1)'(QUEUE_LEN));
      del_error      <= valid_delete && !del_ok;
    end
  end

  // Key storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int s = 0; s < QUEUE_LEN; s++) begin
      if (alloc_hit[s]) begin
        keys_q[s] <= keys_in;
      end
    end
  end

endmodule

// File: tb/tb_rw_solve_mk.sv
module tb_rw_solve_mk;

  localparam int KW  = 12;
  localparam int NK  = 2;
  localparam int QL  = 64;
  localparam int LW  = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              valid_insert = 1'b0;
  logic [NK*KW-1:0]  keys_in = '0;
  logic              valid_delete = 1'b0;
  logic [LW-1:0]     del_loc_in = '0;
  logic              valid_out;
  logic [NK*KW-1:0]  keys_out;
  logic              insert_success;
  logic [LW-1:0]     insert_loc;
  logic [NK-1:0]     conflict_mask;
  logic              full;
  logic [LW:0]       occupancy;
  logic              del_error;

  int errors = 0;
  int checks = 0;

  rw_solve_mk #(.KEY_W(KW), .NUM_KEYS(NK), .QUEUE_LEN(QL), .LOC_WIDTH(LW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_insert   (valid_insert),
    .keys_in        (keys_in),
    .valid_delete   (valid_delete),
    .del_loc_in     (del_loc_in),
    .valid_out      (valid_out),
    .keys_out       (keys_out),
    .insert_success (insert_success),
    .insert_loc     (insert_loc),
    .conflict_mask  (conflict_mask),
    .full           (full),
    .occupancy      (occupancy),
    .del_error      (del_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ins;
    int k0;
    int k1;
    int del;
    int dloc;
    int e_succ;
    int e_loc;
    int e_mask;
    int e_occ;
    int e_full;
    int e_derr;
  } vec_t;

  vec_t vt[$];
  bit   used[QL];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int ins, input int k0, input int k1, input int del, input int dloc);
    valid_insert = (ins != 0);
    keys_in      = {KW'(k1), KW'(k0)};
    valid_delete = (del != 0);
    del_loc_in   = LW'(dloc);
  endtask

  task automatic idle();
    valid_insert = 1'b0;
    valid_delete = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string nm);
    drive(v.ins, v.k0, v.k1, v.del, v.dloc);
    @(posedge clk);
    #1;
    idle();
    chk({nm, ".valid_out"}, valid_out, v.ins);
    chk({nm, ".success"}, insert_success, v.e_succ);
    chk({nm, ".loc"}, insert_loc, v.e_loc);
    chk({nm, ".mask"}, conflict_mask, v.e_mask);
    chk({nm, ".occ"}, occupancy, v.e_occ);
    chk({nm, ".full"}, full, v.e_full);
    chk({nm, ".del_error"}, del_error, v.e_derr);
    if (v.ins != 0) chk({nm, ".keys_out"}, keys_out, {KW'(v.k1), KW'(v.k0)});
  endtask

  function automatic int first_free();
    for (int i = 0; i < QL; i++) if (!used[i]) return i;
    return -1;
  endfunction

  initial begin
    int exp_loc;
    bit feat;
`ifdef RW_SOLVE_SAME_CYCLE_FREE_EN
    feat = 1'b1;
`else
    feat = 1'b0;
`endif

    // Reset held with random insert traffic: everything stays at zero.
    for (int c = 0; c < 5; c++) begin
      valid_insert = 1'($urandom_range(0, 1));
      keys_in      = NK*KW'($urandom);
      @(posedge clk);
      #1;
      chk($sformatf("rst%0d.valid_out", c), valid_out, 0);
      chk($sformatf("rst%0d.occ", c), occupancy, 0);
      chk($sformatf("rst%0d.full", c), full, 0);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    //        ins k0  k1  del dloc succ loc mask occ full derr
    vt.push_back('{1,  1,  2, 0, 0,  1, 0, 0, 1, 0, 0});
    vt.push_back('{1,  1,  3, 0, 0,  0, 0, 1, 1, 0, 0});
    vt.push_back('{1,  7,  2, 0, 0,  0, 0, 2, 1, 0, 0});
    vt.push_back('{1,  1,  2, 0, 0,  0, 0, 3, 1, 0, 0});
    vt.push_back('{1,  3,  4, 0, 0,  1, 1, 0, 2, 0, 0});
    vt.push_back('{1,  5,  6, 0, 0,  1, 2, 0, 3, 0, 0});
    vt.push_back('{1,  7,  8, 0, 0,  1, 3, 0, 4, 0, 0});
    vt.push_back('{1,  9, 10, 0, 0,  1, 4, 0, 5, 0, 0});
    vt.push_back('{1, 11, 12, 0, 0,  1, 5, 0, 6, 0, 0});
    vt.push_back('{1, 13, 14, 0, 0,  1, 6, 0, 7, 0, 0});
    vt.push_back('{1,  5,  6, 0, 0,  0, 0, 3, 7, 0, 0});
    vt.push_back('{0,  0,  0, 1, 3,  0, 0, 0, 6, 0, 0});
    vt.push_back('{0,  0,  0, 1, 3,  0, 0, 0, 6, 0, 1});
    vt.push_back('{0,  0,  0, 1, 20, 0, 0, 0, 6, 0, 1});
    vt.push_back('{1, 20, 21, 0, 0,  1, 3, 0, 7, 0, 0});
    // Insert (1,2) while deleting its own slot 0: no conflict reported.
    vt.push_back('{1,  1,  2, 1, 0,  1, feat ? 0 : 7, 0, 7, 0, 0});
    vt.push_back('{1,  1,  2, 0, 0,  0, 0, 3, 7, 0, 0});

    for (int i = 0; i < vt.size(); i++) apply(vt[i], $sformatf("vec%0d", i));

    // Fill remaining slots, tracking the expected lowest-free allocation.
    for (int i = 0; i < QL; i++) used[i] = feat ? (i <= 6) : (i >= 1 && i <= 7);
    for (int i = 0; i < QL - 7; i++) begin
      exp_loc = first_free();
      drive(1, 100 + i, 300 + i, 0, 0);
      @(posedge clk);
      #1;
      idle();
      chk($sformatf("fill%0d.success", i), insert_success, 1);
      chk($sformatf("fill%0d.loc", i), insert_loc, exp_loc);
      if (exp_loc >= 0) used[exp_loc] = 1'b1;
    end
    chk("fill.full", full, 1);
    chk("fill.occ", occupancy, QL);

    apply('{1, 900, 901, 0, 0, 0, 0, 0, 64, 1, 0}, "full_ins");
    if (feat) apply('{1, 900, 901, 1, 10, 1, 10, 0, 64, 1, 0}, "full_insdel");
    else      apply('{1, 900, 901, 1, 10, 0, 0,  0, 63, 0, 0}, "full_insdel");

    // Reset asserted mid-stream while a result is on the outputs.
    if (feat) apply('{1, 900, 901, 0, 0, 0, 0,  3, 64, 1, 0}, "pre_rst");
    else      apply('{1, 900, 901, 0, 0, 1, 10, 0, 64, 1, 0}, "pre_rst");
    rst_n = 1'b0;
    #1;
    chk("midrst.valid_out", valid_out, 0);
    chk("midrst.success", insert_success, 0);
    chk("midrst.loc", insert_loc, 0);
    chk("midrst.keys_out", keys_out, 0);
    chk("midrst.occ", occupancy, 0);
    chk("midrst.full", full, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply('{1, 900, 901, 0, 0, 1, 0, 0, 1, 0, 0}, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rw_solve_mk.md
Name: rw_solve_mk

Overview:
Multi-key conflict table, the parametrised successor of the single-clock read/write conflict solver. It holds up to QUEUE_LEN entries, each a tuple of NUM_KEYS key fields. An insert is accepted only if none of its key fields matches the same field of any resident entry. The block returns the allocated slot and a per-field conflict mask; entries are released by slot index. It sits between the request front-end and the matching engine.

Parameters:
KEY_W, 12, width of one key field
NUM_KEYS, 2, key fields per entry (>=1)
QUEUE_LEN, 64, table slots (>=2, need not be a power of 2)
LOC_WIDTH, 6, slot index width, = clog2(QUEUE_LEN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_insert  in  1  insert request this cycle
keys_in  in  NUM_KEYS*KEY_W  key tuple; field i = bits [i*KEY_W +: KEY_W]
valid_delete  in  1  delete request this cycle
del_loc_in  in  LOC_WIDTH  slot to release
valid_out  out  1  insert result valid (1-cycle pulse per request)
keys_out  out  NUM_KEYS*KEY_W  echo of the requested tuple
insert_success  out  1  insert accepted
insert_loc  out  LOC_WIDTH  allocated slot; 0 on failure
conflict_mask  out  NUM_KEYS  bit i set = field i matched a resident entry
full  out  1  all slots occupied (registered)
occupancy  out  LOC_WIDTH+1  resident entry count (registered)
del_error  out  1  1-cycle pulse: delete targeted an empty or out-of-range slot

Behaviour:
- Reset (async, rst_n=0): all slot valid bits cleared. All outputs go to 0. Any in-flight result is dropped. Key storage need not be reset.
- Insert latency is 1 cycle. A request at edge N is evaluated against table state before edge N. Results appear on the outputs after edge N and are held until the next edge. valid_out=0 when there was no request.
- Conflict check: field i of keys_in is compared with field i of every valid slot only (no cross-field compare). conflict_mask is the OR over slots.
- Success requires conflict_mask==0 and at least one free slot. The lowest-index free slot is allocated. The tuple is written and the valid bit set at the same edge.
- Failure (conflict or full): no state change, insert_success=0, insert_loc=0. conflict_mask is still reported; it is all-0 for a pure full failure.
- Back-to-back inserts: the entry written at edge N is visible to the request at edge N+1, so duplicates in consecutive cycles are rejected.
- Delete: takes effect at the edge. No output except del_error, which pulses 1 cycle later if the slot was invalid or del_loc_in>=QUEUE_LEN; in that case the table is unchanged.
- Simultaneous insert and delete, default build: the slot being deleted is excluded from the conflict compare but is NOT allocatable that cycle. If the table is full, the insert fails.
- Insert and delete of the same slot in one cycle cannot occur by construction, because a deleted slot is never allocated in the default build.
- occupancy: +1 on successful insert, -1 on valid delete, unchanged if both happen. full = (occupancy==QUEUE_LEN).

Optional Feature:
RW_SOLVE_SAME_CYCLE_FREE_EN:
- When defined, a slot being validly deleted in the same cycle counts as free for allocation. If it is the lowest free slot it is reused immediately, with the new tuple written and the valid bit kept set. A full table then accepts an insert paired with a delete, and occupancy is unchanged.
- When undefined, the default rule above applies.

Decomposition:
- Package rw_solve_pkg: KEY_W/NUM_KEYS defaults, key-field extract helper, LOC_WIDTH derivation function.
- Sub-module lowest_free_enc: parametrised first-zero priority encoder over the QUEUE_LEN valid vector, outputs index and any_free.

Test Plan:
- Reset held 5 cycles with random valid_insert -> valid_out=0, occupancy=0, full=0 throughout. Release reset, then insert (1,2) -> next cycle insert_success=1, insert_loc=0, occupancy=1.
- With (1,2) resident, insert (1,3) then (7,2) -> both fail; conflict_mask=01 then 10; insert (1,2) -> mask=11.
- Inserts (3,4),(5,6),... in 6 consecutive cycles -> locs 1..6, all succeed; then re-insert (5,6) -> fail, mask=11.
- Fill all 64 slots, insert (900,901) -> fail, mask=00, full=1. Delete loc 10 together with insert (900,901): default -> fail; with RW_SOLVE_SAME_CYCLE_FREE_EN -> success at loc 10, occupancy stays 64.
- Delete loc 3 twice -> first frees the slot (occupancy -1), second pulses del_error, no change. Next insert lands at loc 3.
- Insert (1,2) and delete the slot holding (1,2) in the same cycle -> no conflict reported. Default build: loc = lowest other free slot. Assert rst_n mid-stream -> all outputs 0 immediately.
